// File: rtl/traffic_lights_pkg.sv
// Shared command-port definitions for traffic_lights and its front-end sequencer.
package traffic_lights_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [CMD_W-1:0] {
    ENABLE        = 3'd0,
    DISABLE       = 3'd1,
    NOTRANSITION  = 3'd2,
    SET_GREEN_MS  = 3'd3,
    SET_RED_MS    = 3'd4,
    SET_YELLOW_MS = 3'd5
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] red;
    logic [DATA_W-1:0] yellow;
    logic [DATA_W-1:0] green;
  } time_preset_t;

  function automatic logic preset_ok(time_preset_t p);
    return (p.red != '0) && (p.yellow != '0) && (p.green != '0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester preferred on a tie.
module rr_arb2 #(
  parameter bit RstPtr = 1'b0
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    ptr_d = ptr_q;
    // Priority passes to whichever requester was not granted.
    if (accept_i && (gnt_o != 2'b00)) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) ptr_q <= RstPtr;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/traffic_cmd_sequencer.sv
// Arbitrates preset/mode requesters onto the traffic_lights command port as gapped pulses.
module traffic_cmd_sequencer
  import traffic_lights_pkg::*;
#(
  parameter int unsigned CMD_GAP        = 1,
  parameter bit          TIE_MODE_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              preset_valid_i,
  output logic              preset_ready_o,
  input  logic [DATA_W-1:0] preset_red_ms_i,
  input  logic [DATA_W-1:0] preset_yellow_ms_i,
  input  logic [DATA_W-1:0] preset_green_ms_i,
  input  logic              preset_auto_enable_i,
  input  logic              mode_valid_i,
  output logic              mode_ready_o,
  input  logic [CMD_W-1:0]  mode_cmd_i,
  output logic [CMD_W-1:0]  cmd_type_o,
  output logic              cmd_valid_o,
  output logic [DATA_W-1:0] cmd_data_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  localparam logic [3:0] GapLast = 4'(CMD_GAP - 1);

  state_e          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [3:0]      gap_q, gap_d;
  logic            is_mode_q, is_mode_d;
  logic            auto_q, auto_d;
  logic [CMD_W-1:0] mode_q, mode_d;
  time_preset_t    times_q, times_d;
  logic            err_q, err_d;
  logic [1:0]      gnt;
  logic            idle;
  logic            last_step;
  time_preset_t    req_times;

  assign idle      = (state_q == StIdle);
  assign req_times = {preset_red_ms_i, preset_yellow_ms_i, preset_green_ms_i};
  assign last_step = is_mode_q ? (step_q == 3'd0) : (step_q == (auto_q ? 3'd4 : 3'd3));

  rr_arb2 #(
    .RstPtr (TIE_MODE_FIRST)
  ) u_arb (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .req_i    ({mode_valid_i & idle, preset_valid_i & idle}),
    .accept_i (idle),
    .gnt_o    (gnt)
  );

  assign preset_ready_o = gnt[0];
  assign mode_ready_o   = gnt[1];
  assign busy_o         = !idle;
  assign err_o          = err_q;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    gap_d       = gap_q;
    is_mode_d   = is_mode_q;
    auto_d      = auto_q;
    mode_d      = mode_q;
    times_d     = times_q;
    err_d       = 1'b0;
    cmd_valid_o = 1'b0;
    cmd_type_o  = '0;
    cmd_data_o  = '0;
    case (state_q)
      StIdle: begin
        step_d = 3'd0;
        if (gnt[0]) begin
          times_d   = req_times;
          auto_d    = preset_auto_enable_i;
          is_mode_d = 1'b0;
          if (preset_ok(req_times)) state_d = StIssue;
          else                      err_d   = 1'b1;
        end else if (gnt[1]) begin
          mode_d    = mode_cmd_i;
          is_mode_d = 1'b1;
          if (mode_cmd_i <= 3'd2) state_d = StIssue;
          else                    err_d   = 1'b1;
        end
      end
      StIssue: begin
        cmd_valid_o = 1'b1;
        if (is_mode_q) begin
          cmd_type_o = mode_q;
        end else begin
          case (step_q)
            3'd0: cmd_type_o = NOTRANSITION;
            3'd1: begin cmd_type_o = SET_RED_MS;    cmd_data_o = times_q.red;    end
            3'd2: begin cmd_type_o = SET_YELLOW_MS; cmd_data_o = times_q.yellow; end
            3'd3: begin cmd_type_o = SET_GREEN_MS;  cmd_data_o = times_q.green;  end
            default: cmd_type_o = ENABLE;
          endcase
        end
        gap_d   = GapLast;
        state_d = StGap;
      end
      StGap: begin
        if (gap_q == 4'd0) begin
          if (last_step) begin
            state_d = StIdle;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = StIssue;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= StIdle;
      step_q    <= '0;
      gap_q     <= '0;
      is_mode_q <= 1'b0;
      auto_q    <= 1'b0;
      mode_q    <= '0;
      times_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      gap_q     <= gap_d;
      is_mode_q <= is_mode_d;
      auto_q    <= auto_d;
      mode_q    <= mode_d;
      times_q   <= times_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_traffic_cmd_sequencer.sv
// Self-checking bench: timeline reference model, request table, corner sequences, random traffic.
module tb_traffic_cmd_sequencer;
  import traffic_lights_pkg::*;

  localparam int unsigned Gap = 1;
  localparam bit TieMode = 1'b1;

  logic        clk_i = 1'b0;
  logic        srst_i;
  logic        pv, pready, pauto, mv, mready, cvalid, busy, err;
  logic [15:0] pr, py, pg, cdata;
  logic [2:0]  mcmd, ctype;

  always #5 clk_i = ~clk_i;

  traffic_cmd_sequencer #(
    .CMD_GAP        (Gap),
    .TIE_MODE_FIRST (TieMode)
  ) dut (
    .clk_i                (clk_i),
    .srst_i               (srst_i),
    .preset_valid_i       (pv),
    .preset_ready_o       (pready),
    .preset_red_ms_i      (pr),
    .preset_yellow_ms_i   (py),
    .preset_green_ms_i    (pg),
    .preset_auto_enable_i (pauto),
    .mode_valid_i         (mv),
    .mode_ready_o         (mready),
    .mode_cmd_i           (mcmd),
    .cmd_type_o           (ctype),
    .cmd_valid_o          (cvalid),
    .cmd_data_o           (cdata),
    .busy_o               (busy),
    .err_o                (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a timeline of expected command pulses plus the busy horizon.
  typedef struct {
    int         at;
    logic [2:0] t;
    logic [15:0] d;
  } exp_cmd_t;

  exp_cmd_t    q[$];
  int          free_at = 0;
  int          err_at = -1;
  bit          prio_mode = TieMode;
  bit          chk_en = 1'b0;
  bit          m_idle, m_ep, m_em, m_ev;
  logic [2:0]  m_et;
  logic [15:0] m_ed;

  function automatic logic [2:0] burst_type(input int k);
    case (k)
      0: return NOTRANSITION;
      1: return SET_RED_MS;
      2: return SET_YELLOW_MS;
      3: return SET_GREEN_MS;
      default: return ENABLE;
    endcase
  endfunction

  always @(negedge clk_i) begin
    cyc++;
    if (chk_en) begin
      m_idle = (cyc >= free_at);
      m_ep = m_idle && pv && (!mv || !prio_mode);
      m_em = m_idle && mv && (!pv || prio_mode);
      m_ev = 1'b0; m_et = '0; m_ed = '0;
      if (q.size() > 0 && q[0].at == cyc) begin
        m_ev = 1'b1; m_et = q[0].t; m_ed = q[0].d;
        void'(q.pop_front());
      end
      chk("preset_ready", pready, m_ep);
      chk("mode_ready", mready, m_em);
      chk("cmd_valid", cvalid, m_ev);
      chk("cmd_type", ctype, m_et);
      chk("cmd_data", cdata, m_ed);
      chk("busy", busy, !m_idle);
      chk("err", err, cyc == err_at);
      if (srst_i) begin
        q.delete();
        free_at = cyc + 1;
        err_at = -1;
        prio_mode = TieMode;
      end else if (m_ep) begin
        prio_mode = 1'b1;
        if (pr == 0 || py == 0 || pg == 0) begin
          err_at = cyc + 1;
        end else begin
          for (int k = 0; k < (pauto ? 5 : 4); k++) begin
            exp_cmd_t e;
            e.at = cyc + 1 + k * (1 + Gap);
            e.t = burst_type(k);
            e.d = (k == 1) ? pr : (k == 2) ? py : (k == 3) ? pg : 16'd0;
            q.push_back(e);
          end
          free_at = cyc + 1 + (pauto ? 5 : 4) * (1 + Gap);
        end
      end else if (m_em) begin
        prio_mode = 1'b0;
        if (mcmd > 3'd2) begin
          err_at = cyc + 1;
        end else begin
          exp_cmd_t e;
          e.at = cyc + 1; e.t = mcmd; e.d = 16'd0;
          q.push_back(e);
          free_at = cyc + 1 + (1 + Gap);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && busy; n++) step();
    chk("idle_wait", busy, 1'b0);
  endtask

  task automatic set_preset(input logic [15:0] r, input logic [15:0] y, input logic [15:0] g,
                            input logic a);
    pv = 1'b1; pr = r; py = y; pg = g; pauto = a;
  endtask

  typedef struct {
    bit          is_mode;
    logic [2:0]  mc;
    logic [15:0] r, y, g;
    bit          a;
    int          exp_err;
    int          exp_n;
    logic [2:0]  exp_lt;
    logic [15:0] exp_ld;
  } vec_t;

  vec_t        vecs[9];
  int          nc, ne, found;
  logic [2:0]  lt;
  logic [15:0] ld;
  logic [15:0] got[5];
  int          order[$];

  initial begin
    vecs[0] = '{1'b0, 3'd0, 16'd100, 16'd50, 16'd200, 1'b1, 0, 5, ENABLE, 16'd0};
    vecs[1] = '{1'b0, 3'd0, 16'd10, 16'd20, 16'd30, 1'b0, 0, 4, SET_GREEN_MS, 16'd30};
    vecs[2] = '{1'b0, 3'd0, 16'd100, 16'd0, 16'd200, 1'b1, 1, 0, 3'd0, 16'd0};
    vecs[3] = '{1'b0, 3'd0, 16'd0, 16'd5, 16'd5, 1'b0, 1, 0, 3'd0, 16'd0};
    vecs[4] = '{1'b1, DISABLE, 16'd0, 16'd0, 16'd0, 1'b0, 0, 1, DISABLE, 16'd0};
    vecs[5] = '{1'b1, ENABLE, 16'd0, 16'd0, 16'd0, 1'b0, 0, 1, ENABLE, 16'd0};
    vecs[6] = '{1'b1, NOTRANSITION, 16'd0, 16'd0, 16'd0, 1'b0, 0, 1, NOTRANSITION, 16'd0};
    vecs[7] = '{1'b1, 3'd5, 16'd0, 16'd0, 16'd0, 1'b0, 1, 0, 3'd0, 16'd0};
    vecs[8] = '{1'b1, 3'd7, 16'd0, 16'd0, 16'd0, 1'b0, 1, 0, 3'd0, 16'd0};

    srst_i = 1'b1; pv = 0; mv = 0; pr = 0; py = 0; pg = 0; pauto = 0; mcmd = 0;
    step();
    chk_en = 1'b1;
    step();
    srst_i = 1'b0;
    step();

    // Request table: each applied alone from IDLE.
    for (int i = 0; i < 9; i++) begin
      wait_idle();
      if (vecs[i].is_mode) begin
        mv = 1'b1; mcmd = vecs[i].mc;
      end else begin
        set_preset(vecs[i].r, vecs[i].y, vecs[i].g, vecs[i].a);
      end
      nc = 0; ne = 0; lt = '0; ld = '0;
      @(negedge clk_i);
      @(posedge clk_i); #1;
      pv = 1'b0; mv = 1'b0;
      for (int k = 0; k < 14; k++) begin
        @(negedge clk_i);
        if (cvalid) begin nc++; lt = ctype; ld = cdata; end
        if (err) ne++;
      end
      chk("vec_err_count", ne, vecs[i].exp_err);
      chk("vec_cmd_count", nc, vecs[i].exp_n);
      chk("vec_last_type", lt, vecs[i].exp_lt);
      chk("vec_last_data", ld, vecs[i].exp_ld);
      step();
    end

    // Inputs altered right after the handshake must not leak into the burst.
    wait_idle();
    set_preset(16'd100, 16'd50, 16'd200, 1'b1);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    set_preset(16'd7, 16'd7, 16'd7, 1'b1);
    pv = 1'b0;
    nc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (cvalid) begin
        if (nc < 5) got[nc] = cdata;
        nc++;
      end
    end
    chk("capture_count", nc, 5);
    chk("capture_red", got[1], 16'd100);
    chk("capture_yellow", got[2], 16'd50);
    chk("capture_green", got[3], 16'd200);

    // A preset arriving during a mode command waits until IDLE.
    wait_idle();
    mv = 1'b1; mcmd = DISABLE;
    step();
    mv = 1'b0;
    set_preset(16'd3, 16'd4, 16'd5, 1'b0);
    for (int k = 0; k < 4; k++) step();
    pv = 1'b0;

    // Reset in the gap after SET_RED drops the rest of the burst.
    wait_idle();
    set_preset(16'd100, 16'd50, 16'd200, 1'b1);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    pv = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk_i);
      if (cvalid && ctype == SET_RED_MS) found = 1;
    end
    chk("saw_set_red", found, 1);
    @(posedge clk_i); #1;
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    nc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_i);
      if (cvalid) nc++;
    end
    chk("no_cmd_after_reset", nc, 0);
    step();
    set_preset(16'd9, 16'd8, 16'd7, 1'b0);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    pv = 1'b0;
    @(negedge clk_i);
    chk("restart_first_type", ctype, NOTRANSITION);

    // Both requesters continuously valid from reset: grants alternate, mode first.
    step();
    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    set_preset(16'd1, 16'd2, 16'd3, 1'b0);
    mv = 1'b1; mcmd = ENABLE;
    order.delete();
    for (int k = 0; k < 60 && order.size() < 4; k++) begin
      @(negedge clk_i);
      if (mready) order.push_back(1);
      if (pready) order.push_back(0);
    end
    chk("grant_count", order.size(), 4);
    for (int k = 0; k < order.size() && k < 4; k++) chk("grant_order", order[k], (k % 2) == 0);
    @(posedge clk_i); #1;
    pv = 1'b0; mv = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      srst_i = ($urandom_range(0, 199) == 0);
      pv = ($urandom_range(0, 2) != 0);
      mv = ($urandom_range(0, 2) == 0);
      pr = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      py = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      pg = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      pauto = 1'($urandom_range(0, 1));
      mcmd = 3'($urandom_range(0, 7));
    end
    step();
    srst_i = 1'b0; pv = 1'b0; mv = 1'b0;
    for (int c = 0; c < 15; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
